frame_buffer_pp: RTL and testbench

Parametrised ping-pong frame buffer and successor to the single-bank camera-to-HDMI store. An AXI4-Stream video input is channel-truncated and written into one bank of an inferred dual-bank RAM. A frame-synchronous reader scans the other bank. Banks swap only at a read-side frame start, so the display never shows a torn frame; short, long and dropped frames are detected and reported.

---
 rtl/frame_buffer_pkg.sv | 28 ++
 rtl/fb_dpram.sv | 26 ++
 rtl/frame_buffer_pp.sv | 164 ++++++++++++++++
 tb/tb_frame_buffer_pp.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/frame_buffer_pkg.sv
// Shared helpers for the ping-pong frame buffer: geometry derivation and
// the bit mappings used to truncate input pixels and pad stored pixels.
package frame_buffer_pkg;

  function automatic int calc_frame_pix(int h_active, int v_active);
    return h_active * v_active;
  endfunction

  function automatic int calc_aw(int frame_pix);
    return (frame_pix > 1) ? $clog2(frame_pix) : 1;
  endfunction

  // Stored bit j comes from the top st_w bits of its input channel.
  function automatic int trunc_src_bit(int j, int in_w, int st_w);
    return (j / st_w) * in_w + (in_w - st_w) + (j % st_w);
  endfunction

  // Output bit j maps to a stored bit, or -1 where it is a padding one.
  function automatic int pad_src_bit(int j, int st_w, int out_w);
    int pad;
    int b;
    pad = out_w - st_w;
    b   = j % out_w;
    if (b < pad) return -1;
    return (j / out_w) * st_w + (b - pad);
  endfunction

endpackage

// File: rtl/fb_dpram.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
// No reset on storage or read data so synthesis maps it onto block RAM.
module fb_dpram #(
  parameter int DW = 9,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/frame_buffer_pp.sv
// Ping-pong frame buffer: AXI4-Stream video fills one bank while the
// frame-synchronous reader scans the other; banks swap only at rd_sof.
module frame_buffer_pp
  import frame_buffer_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int NUM_CH   = 3,
  parameter int IN_CH_W  = 8,
  parameter int ST_CH_W  = 3,
  parameter int OUT_CH_W = 4,
  parameter int CNT_W    = 16
) (
  input  logic                        Cclk,
  input  logic                        rstn,
  output logic                        s_axis_video_tready,
  input  logic [NUM_CH*IN_CH_W-1:0]   s_axis_video_tdata,
  input  logic                        s_axis_video_tvalid,
  input  logic                        s_axis_video_tuser,
  input  logic                        s_axis_video_tlast,
  input  logic                        rd_sof,
  input  logic                        rd_en,
  output logic [NUM_CH*OUT_CH_W-1:0]  rd_data,
  output logic                        rd_valid,
  output logic                        frame_avail,
  output logic [CNT_W-1:0]            drop_cnt,
  output logic                        err_short,
  output logic                        err_long
);

  localparam int FRAME_PIX = calc_frame_pix(H_ACTIVE, V_ACTIVE);
  localparam int AW        = calc_aw(FRAME_PIX);
  localparam int SW        = NUM_CH * ST_CH_W;
  localparam int OW        = NUM_CH * OUT_CH_W;
  localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_PIX - 1);

  logic          wr_bank, rd_bank;
  logic [AW-1:0] waddr, raddr;
  logic          pending, in_frame, got_sof;
  logic          wr_en_q;
  logic [AW:0]   wr_addr_q;
  logic [SW-1:0] wr_data_q;
  logic          avail_q;
  logic [SW-1:0] st_word, ram_q;
  logic [OW-1:0] pad_word;

  logic          sof_acc, cont_acc, ovf_acc, acc, complete, swap;
  logic [AW-1:0] acc_addr, rd_addr_now;
  logic          rd_bank_now, avail_now;
  logic          unused_in;

  assign s_axis_video_tready = 1'b1;
  // tlast and the dropped channel LSBs carry nothing the store needs.
  assign unused_in = ^{s_axis_video_tlast, s_axis_video_tdata};

  for (genvar j = 0; j < SW; j++) begin : g_trunc
    assign st_word[j] = s_axis_video_tdata[trunc_src_bit(j, IN_CH_W, ST_CH_W)];
  end

  for (genvar j = 0; j < OW; j++) begin : g_pad
    localparam int SRC = pad_src_bit(j, ST_CH_W, OUT_CH_W);
    if (SRC < 0) begin : g_one
      assign pad_word[j] = 1'b1;
    end else begin : g_bit
      assign pad_word[j] = ram_q[SRC];
    end
  end

  always_comb begin
    sof_acc  = s_axis_video_tvalid & s_axis_video_tuser;
    cont_acc = s_axis_video_tvalid & ~s_axis_video_tuser & in_frame;
    ovf_acc  = s_axis_video_tvalid & ~s_axis_video_tuser & ~in_frame & got_sof;
    acc      = sof_acc | cont_acc;
    acc_addr = sof_acc ? '0 : waddr;
    complete = acc && (acc_addr == LAST_ADDR);
    // A pending frame that is being overwritten by a newer one is not shown;
    // the swap waits for that newer frame to complete.
    swap        = rd_sof & ((pending & ~in_frame) | complete);
    rd_addr_now = rd_sof ? '0 : raddr;
    rd_bank_now = swap ? wr_bank : rd_bank;
    avail_now   = frame_avail | swap;
  end

  always_ff @(posedge Cclk or negedge rstn) begin
    if (!rstn) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      waddr     <= '0;
      in_frame  <= 1'b0;
      got_sof   <= 1'b0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
    end else begin
      wr_en_q <= acc;
      if (acc) begin
        wr_addr_q <= {wr_bank, acc_addr};
        wr_data_q <= st_word;
        if (complete) begin
          in_frame <= 1'b0;
          waddr    <= acc_addr;
        end else begin
          in_frame <= 1'b1;
          waddr    <= acc_addr + 1'b1;
        end
      end
      if (sof_acc) begin
        got_sof <= 1'b1;
        if (in_frame) err_short <= 1'b1;
      end
      if (ovf_acc) err_long <= 1'b1;
    end
  end

  always_ff @(posedge Cclk or negedge rstn) begin
    if (!rstn) begin
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b1;
      pending     <= 1'b0;
      frame_avail <= 1'b0;
      drop_cnt    <= '0;
    end else if (swap) begin
      wr_bank     <= ~wr_bank;
      rd_bank     <= ~rd_bank;
      pending     <= 1'b0;
      frame_avail <= 1'b1;
    end else if (complete) begin
      pending <= 1'b1;
      if (pending && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  always_ff @(posedge Cclk or negedge rstn) begin
    if (!rstn) begin
      raddr    <= '0;
      rd_valid <= 1'b0;
      avail_q  <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        raddr   <= (rd_addr_now == LAST_ADDR) ? '0 : rd_addr_now + 1'b1;
        avail_q <= avail_now;
      end else if (rd_sof) begin
        raddr <= '0;
      end
    end
  end

  assign rd_data = avail_q ? pad_word : '0;

  fb_dpram #(
    .DW (SW),
    .AW (AW + 1)
  ) u_ram (
    .clk   (Cclk),
    .we    (wr_en_q),
    .waddr (wr_addr_q),
    .wdata (wr_data_q),
    .re    (rd_en),
    .raddr ({rd_bank_now, rd_addr_now}),
    .rdata (ram_q)
  );

endmodule

// File: tb/tb_frame_buffer_pp.sv
// Directed bench for frame_buffer_pp on a 4x2 frame; expected pixels are
// built from the seed/index pattern used to generate the input stream.
module tb_frame_buffer_pp;

  localparam int H = 4, V = 2, NCH = 3, IW = 8, SW = 3, OW = 4, CW = 16;
  localparam int NPIX = H * V;

  logic              Cclk = 1'b0;
  logic              rstn;
  logic              tready;
  logic [NCH*IW-1:0] tdata;
  logic              tvalid, tuser, tlast;
  logic              rd_sof, rd_en;
  logic [NCH*OW-1:0] rd_data;
  logic              rd_valid, frame_avail;
  logic [CW-1:0]     drop_cnt;
  logic              err_short, err_long;

  int total = 0;
  int bad   = 0;

  always #5 Cclk = ~Cclk;

  frame_buffer_pp #(
    .H_ACTIVE (H), .V_ACTIVE (V), .NUM_CH (NCH), .IN_CH_W (IW),
    .ST_CH_W (SW), .OUT_CH_W (OW), .CNT_W (CW)
  ) dut (
    .Cclk                (Cclk),
    .rstn                (rstn),
    .s_axis_video_tready (tready),
    .s_axis_video_tdata  (tdata),
    .s_axis_video_tvalid (tvalid),
    .s_axis_video_tuser  (tuser),
    .s_axis_video_tlast  (tlast),
    .rd_sof              (rd_sof),
    .rd_en               (rd_en),
    .rd_data             (rd_data),
    .rd_valid            (rd_valid),
    .frame_avail         (frame_avail),
    .drop_cnt            (drop_cnt),
    .err_short           (err_short),
    .err_long            (err_long)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Channel k of pixel i carries stored value (i+seed+k)%8 in its top 3 bits;
  // the low 5 bits are junk that truncation must drop.
  function automatic logic [NCH*IW-1:0] pix_in(int i, int seed);
    logic [NCH*IW-1:0] v;
    for (int k = 0; k < NCH; k++) v[k*IW +: IW] = {3'((i + seed + k) & 7), 5'h15};
    return v;
  endfunction

  function automatic logic [NCH*OW-1:0] pix_out(int i, int seed);
    logic [NCH*OW-1:0] v;
    for (int k = 0; k < NCH; k++) v[k*OW +: OW] = {3'((i + seed + k) & 7), 1'b1};
    return v;
  endfunction

  task automatic tick();
    @(posedge Cclk);
    #1;
  endtask

  task automatic send(input int i, input int seed, input logic user);
    tvalid = 1'b1;
    tuser  = user;
    tdata  = pix_in(i, seed);
    tlast  = ((i % H) == H - 1);
    tick();
    tvalid = 1'b0;
    tuser  = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic send_frame(input int seed);
    for (int i = 0; i < NPIX; i++) send(i, seed, i == 0);
  endtask

  // rd_sof pulse, then NPIX+1 reads: the extra read checks the wrap to pixel 0.
  task automatic read_frame(input string tag, input int seed, input logic blank);
    rd_sof = 1'b1;
    tick();
    rd_sof = 1'b0;
    for (int i = 0; i <= NPIX; i++) begin
      rd_en = 1'b1;
      tick();
      check({tag, "_valid"}, 32'(rd_valid), 32'd1);
      check({tag, "_data"}, 32'(rd_data), blank ? 32'd0 : 32'(pix_out(i % NPIX, seed)));
    end
    rd_en = 1'b0;
    tick();
    check({tag, "_idle"}, 32'(rd_valid), 32'd0);
  endtask

  initial begin
    rstn   = 1'b0;
    tdata  = '0;
    tvalid = 1'b0;
    tuser  = 1'b0;
    tlast  = 1'b0;
    rd_sof = 1'b0;
    rd_en  = 1'b0;
    repeat (3) tick();
    check("rst_tready", 32'(tready), 32'd1);
    check("rst_valid", 32'(rd_valid), 32'd0);
    check("rst_data", 32'(rd_data), 32'd0);
    check("rst_avail", 32'(frame_avail), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    check("rst_short", 32'(err_short), 32'd0);
    check("rst_long", 32'(err_long), 32'd0);
    rstn = 1'b1;
    tick();

    // Pixels before the first tuser are silently discarded.
    send(1, 0, 1'b0);
    send(2, 0, 1'b0);
    check("pre_sof_long", 32'(err_long), 32'd0);

    read_frame("blank", 0, 1'b1);
    check("blank_avail", 32'(frame_avail), 32'd0);

    send_frame(0);
    tick();
    check("f0_avail_before_sof", 32'(frame_avail), 32'd0);
    read_frame("f0", 0, 1'b0);
    check("f0_avail", 32'(frame_avail), 32'd1);
    check("f0_drop", 32'(drop_cnt), 32'd0);

    send_frame(1);
    send_frame(2);
    check("two_frames_drop", 32'(drop_cnt), 32'd1);
    read_frame("f2", 2, 1'b0);

    for (int i = 0; i < 5; i++) send(i, 3, i == 0);
    check("short_before", 32'(err_short), 32'd0);
    send(0, 4, 1'b1);
    check("short_flag", 32'(err_short), 32'd1);
    read_frame("short_noswap", 2, 1'b0);

    for (int i = 1; i < NPIX; i++) send(i, 4, 1'b0);
    check("long_before", 32'(err_long), 32'd0);
    send(0, 9, 1'b0);
    check("long_flag", 32'(err_long), 32'd1);
    read_frame("long", 4, 1'b0);
    check("long_drop", 32'(drop_cnt), 32'd1);

    // Last pixel of the frame lands in the same cycle as rd_sof.
    for (int i = 0; i < NPIX - 1; i++) send(i, 5, i == 0);
    rd_sof = 1'b1;
    send(NPIX - 1, 5, 1'b0);
    rd_sof = 1'b0;
    check("coinc_drop", 32'(drop_cnt), 32'd1);

    // rd_sof together with rd_en reads address 0 and continues from 1.
    rd_sof = 1'b1;
    rd_en  = 1'b1;
    tick();
    rd_sof = 1'b0;
    check("coinc_p0", 32'(rd_data), 32'(pix_out(0, 5)));
    tick();
    check("coinc_p1", 32'(rd_data), 32'(pix_out(1, 5)));
    tick();
    check("coinc_p2", 32'(rd_data), 32'(pix_out(2, 5)));
    rd_en = 1'b0;
    tick();
    check("hold_data", 32'(rd_data), 32'(pix_out(2, 5)));
    check("hold_valid", 32'(rd_valid), 32'd0);

    rd_en = 1'b1;
    tick();
    check("midread_valid", 32'(rd_valid), 32'd1);
    rstn = 1'b0;
    #1;
    check("async_valid", 32'(rd_valid), 32'd0);
    check("async_data", 32'(rd_data), 32'd0);
    check("async_avail", 32'(frame_avail), 32'd0);
    check("async_drop", 32'(drop_cnt), 32'd0);
    check("async_short", 32'(err_short), 32'd0);
    check("async_long", 32'(err_long), 32'd0);
    rd_en = 1'b0;
    tick();
    rstn = 1'b1;
    tick();

    send_frame(6);
    read_frame("post_rst", 6, 1'b0);
    check("post_rst_avail", 32'(frame_avail), 32'd1);
    check("post_rst_drop", 32'(drop_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
